// File: rtl/cla_mp_add_seq_pkg.sv
// cla_pkg: shared word width, sequencer state encoding and index-width helper
package cla_pkg;
    localparam int WORD_W = 64;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Word index width: clog2(n), never below one bit so a single-word build still has a counter.
    function automatic int idx_w(input int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/cla_mp_add_seq_if.sv
// cla_mp_add_seq_if: request/response bus of the multi-precision add/sub sequencer
// request : in_valid, in_ready, in_a, in_b, in_cin, in_sub
// response: out_valid, out_ready, out_sum, out_cout, out_ovf; status: busy
interface cla_mp_add_seq_if #(parameter int NUM_WORDS = 4);
    localparam int W = NUM_WORDS * cla_pkg::WORD_W;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/cla_mp_add_seq_cla.sv
// carry_look_ahead_64bit: combinational 64-bit adder, 4-bit lookahead groups chained by group carry
// ports: a, b operands; cin carry in; sum result; cout carry out
module carry_look_ahead_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [63:0] g, p, c;
    logic        cy;
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        cy = cin;
        for (int k = 0; k < 64; k += 4) begin
            c[k]   = cy;
            c[k+1] = g[k] | p[k] & cy;
            c[k+2] = g[k+1] | p[k+1] & g[k] | p[k+1] & p[k] & cy;
            c[k+3] = g[k+2] | p[k+2] & g[k+1] | p[k+2] & p[k+1] & g[k] | p[k+2] & p[k+1] & p[k] & cy;
            cy     = g[k+3] | p[k+3] & g[k+2] | p[k+3] & p[k+2] & g[k+1] | p[k+3] & p[k+2] & p[k+1] & g[k]
                   | (&p[k+:4]) & cy;
        end
        sum  = p ^ c;
        cout = cy;
    end
endmodule

// File: rtl/cla_mp_add_seq.sv
// cla_mp_add_seq: NUM_WORDS x 64-bit add/sub, one word per cycle LSW first through a shared CLA
// ports: clk, rst (sync, active-high); bus (slave) carries request, response and busy
module cla_mp_add_seq
    import cla_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input logic clk,
    input logic rst,
    cla_mp_add_seq_if.slave bus
);
    localparam int IW = idx_w(NUM_WORDS);

    state_t                             state;
    logic [IW-1:0]                      idx;
    logic [NUM_WORDS-1:0][WORD_W-1:0]   a_r, b_r, sum_r;
    logic                               sub_r, carry, cout_r, ovf_r;
    logic                               in_ready_r, out_valid_r, busy_r;
    logic [WORD_W-1:0]                  a_w, b_w, s;
    logic                               co, last;

    // Subtraction is A + ~B + carry, so B is inverted word by word and the borrow folded into carry.
    assign a_w  = a_r[idx];
    assign b_w  = b_r[idx] ^ {WORD_W{sub_r}};
    assign last = idx == IW'(NUM_WORDS - 1);

    carry_look_ahead_64bit u_cla (
        .a   (a_w),
        .b   (b_w),
        .cin (carry),
        .sum (s),
        .cout(co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            idx         <= '0;
            carry       <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sub_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r        <= bus.in_a;
                    b_r        <= bus.in_b;
                    sub_r      <= bus.in_sub;
                    carry      <= bus.in_sub ? ~bus.in_cin : bus.in_cin;
                    idx        <= '0;
                    state      <= RUN;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b1;
                end
                RUN: begin
                    sum_r[idx] <= s;
                    carry      <= co;
                    idx        <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout_r      <= co;
                        // Carry into the MSB differs from carry out exactly on signed overflow.
                        ovf_r       <= a_w[WORD_W-1] ^ b_w[WORD_W-1] ^ s[WORD_W-1] ^ co;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.out_sum   = sum_r;
    assign bus.out_cout  = cout_r;
    assign bus.out_ovf   = ovf_r;
endmodule

// File: tb/tb_cla_mp_add_seq.sv
// tb_cla_mp_add_seq: table-driven and sequence checks of cla_mp_add_seq with NUM_WORDS=4
module tb_cla_mp_add_seq;
    localparam int NW = 4;
    localparam int W  = NW * 64;

    typedef struct {
        string        nm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[8];

    always #5 clk = ~clk;

    cla_mp_add_seq_if #(.NUM_WORDS(NW)) bus ();
    cla_mp_add_seq #(.NUM_WORDS(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input vec_t v);
        int n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        chk({v.nm, "_ready"}, W'(bus.in_ready), W'(1));
        bus.in_a = v.a; bus.in_b = v.b; bus.in_cin = v.cin; bus.in_sub = v.sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        // scramble inputs after accept: only latched copies may matter
        bus.in_a = ~v.a; bus.in_b = ~v.b; bus.in_cin = ~v.cin; bus.in_sub = ~v.sub;
    endtask

    task automatic wait_result(input vec_t v);
        int n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        chk({v.nm, "_latency"}, W'(n), W'(NW));
        chk({v.nm, "_sum"}, bus.out_sum, v.sum);
        chk({v.nm, "_cout"}, W'(bus.out_cout), W'(v.cout));
        chk({v.nm, "_ovf"}, W'(bus.out_ovf), W'(v.ovf));
        chk({v.nm, "_busy"}, W'(bus.busy), W'(1));
        chk({v.nm, "_inrdy0"}, W'(bus.in_ready), W'(0));
    endtask

    task automatic ack(input string nm);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, "_ack_inrdy"}, W'(bus.in_ready), W'(1));
        chk({nm, "_ack_ovalid"}, W'(bus.out_valid), W'(0));
        chk({nm, "_ack_busy"}, W'(bus.busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] ones, msb, maxp;
        vec_t bp;
        ones = '1;
        msb  = {1'b1, {(W-1){1'b0}}};
        maxp = {1'b0, {(W-1){1'b1}}};
        tv[0] = '{"allones_p1", ones, W'(0), 1'b1, 1'b0, W'(0), 1'b1, 1'b0};
        tv[1] = '{"word_carry", {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, W'(1), 1'b0, 1'b0,
                  {128'd0, 64'd1, 64'd0}, 1'b0, 1'b0};
        tv[2] = '{"sub5m7", W'(5), W'(7), 1'b0, 1'b1, ones - W'(1), 1'b0, 1'b0};
        tv[3] = '{"maxpos_p1", maxp, W'(1), 1'b0, 1'b0, msb, 1'b0, 1'b1};
        tv[4] = '{"minneg_m1", msb, W'(1), 1'b0, 1'b1, maxp, 1'b1, 1'b1};
        tv[5] = '{"neg_neg", msb, msb, 1'b0, 1'b0, W'(0), 1'b1, 1'b1};
        tv[6] = '{"sub_borrow", W'(10), W'(3), 1'b1, 1'b1, W'(6), 1'b1, 1'b0};
        tv[7] = '{"small_cin", W'(1), W'(2), 1'b1, 1'b0, W'(4), 1'b0, 1'b0};

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_inrdy", W'(bus.in_ready), W'(1));
        chk("rst_ovalid", W'(bus.out_valid), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_sum", bus.out_sum, W'(0));
        chk("rst_cout", W'(bus.out_cout), W'(0));
        chk("rst_ovf", W'(bus.out_ovf), W'(0));

        for (int i = 0; i < 8; i++) begin
            start_op(tv[i]);
            wait_result(tv[i]);
            ack(tv[i].nm);
        end

        // backpressure: result held, requests ignored while DONE
        bp = '{"bp", W'(3), W'(4), 1'b0, 1'b0, W'(7), 1'b0, 1'b0};
        start_op(bp);
        wait_result(bp);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_a = W'(100 + i);
            tick();
            chk("bp_ovalid", W'(bus.out_valid), W'(1));
            chk("bp_sum", bus.out_sum, W'(7));
            chk("bp_inrdy", W'(bus.in_ready), W'(0));
        end
        bus.in_valid = 1'b1;
        ack("bp");
        bus.in_valid = 1'b0;
        start_op(tv[3]);
        wait_result(tv[3]);
        ack("bp_next");

        // reset while RUN at idx=2
        start_op(tv[1]);
        tick(); tick();
        chk("mid_busy", W'(bus.busy), W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_inrdy", W'(bus.in_ready), W'(1));
        chk("mid_ovalid", W'(bus.out_valid), W'(0));
        chk("mid_sum", bus.out_sum, W'(0));
        chk("mid_busy0", W'(bus.busy), W'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_valid", W'(bus.out_valid), W'(0));
        end
        start_op(tv[0]);
        wait_result(tv[0]);
        ack("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
